// File: rtl/shift_rnd_pkg.sv
// Shared widths and the round-robin winner decode used by the arbiter and its bench.
package shift_rnd_pkg;

  localparam int WIDTH_I_DEF     = 9;
  localparam int WIDTH_O_DEF     = 8;
  localparam int WIDTH_SHIFT_DEF = 8;
  localparam int N_REQ_DEF       = 4;

  // Returns {found, index}: first valid requester at or above ptr, wrapping modulo n (n <= 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int n);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && valid[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_rnd_rne.sv
// Arithmetic right shift with round-half-to-even and signed saturation; purely combinational.
module shift_rnd_rne #(
  parameter int width_i     = 9,
  parameter int width_o     = 8,
  parameter int width_shift = 8
) (
  input  logic [width_i-1:0]     i_num,
  input  logic [width_shift-1:0] i_shift,
  output logic [width_o-1:0]     o_rnd
);

  localparam int W1 = width_i + 1;
  localparam int WX = ((W1 > width_o) ? W1 : width_o) + 1;
  localparam logic signed [WX-1:0] MAXV = WX'((1 << (width_o - 1)) - 1);
  localparam logic signed [WX-1:0] MINV = WX'(-(1 << (width_o - 1)));

  logic [31:0]            sh_c;
  logic signed [W1-1:0]   num_x;
  logic signed [W1-1:0]   q;
  logic signed [W1-1:0]   sum;
  logic [W1-1:0]          mask;
  logic [W1-1:0]          half;
  logic [W1-1:0]          rem;
  logic                   round_up;
  logic signed [WX-1:0]   sum_x;

  // Shifts of width_i or more all behave alike (|value| <= 1/2), so clamp there.
  always_comb begin
    sh_c     = (32'(i_shift) > 32'(width_i)) ? 32'(width_i) : 32'(i_shift);
    num_x    = {i_num[width_i-1], i_num};
    q        = num_x >>> sh_c;
    mask     = (W1'(1) << sh_c) - W1'(1);
    half     = mask ^ (mask >> 1);
    rem      = num_x & mask;
    round_up = (sh_c != 0) && ((rem > half) || ((rem == half) && q[0]));
    sum      = q + $signed({{width_i{1'b0}}, round_up});
    sum_x    = WX'(sum);
    if (sum_x > MAXV)      o_rnd = MAXV[width_o-1:0];
    else if (sum_x < MINV) o_rnd = MINV[width_o-1:0];
    else                   o_rnd = sum_x[width_o-1:0];
  end

endmodule

// File: rtl/shift_rnd_arb.sv
// Round-robin arbiter sharing one shift_rnd_rne among n_req requesters; 1-cycle latency,
// one output register that refills in the same cycle it drains (full throughput).
module shift_rnd_arb
  import shift_rnd_pkg::*;
#(
  parameter int width_i     = WIDTH_I_DEF,
  parameter int width_o     = WIDTH_O_DEF,
  parameter int width_shift = WIDTH_SHIFT_DEF,
  parameter int n_req       = N_REQ_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [n_req-1:0]               i_req_valid,
  output logic [n_req-1:0]               o_req_ready,
  input  logic [n_req*width_i-1:0]       i_req_num,
  input  logic [n_req*width_shift-1:0]   i_req_shift,
  output logic [n_req-1:0]               o_rsp_valid,
  input  logic [n_req-1:0]               i_rsp_ready,
  output logic [width_o-1:0]             o_rsp_rnd,
  output logic [$clog2(n_req)-1:0]       o_rsp_id
);

  localparam int IDW = $clog2(n_req);

  logic [3:0]             pick;
  logic                   found;
  logic [IDW-1:0]         win;
  logic                   drain;
  logic                   accept;
  logic [width_i-1:0]     op_num;
  logic [width_shift-1:0] op_shift;
  logic [width_o-1:0]     rnd_w;

  logic                   vld_q, vld_d;
  logic [width_o-1:0]     rnd_q, rnd_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;

  always_comb begin
    pick     = rr_pick(8'(i_req_valid), 3'(rr_ptr_q), n_req);
    found    = pick[3];
    win      = IDW'(pick[2:0]);
    drain    = vld_q && i_rsp_ready[id_q];
    accept   = !i_rst && found && (!vld_q || drain);
    op_num   = i_req_num[win*width_i +: width_i];
    op_shift = i_req_shift[win*width_shift +: width_shift];

    o_req_ready = '0;
    if (accept) o_req_ready[win] = 1'b1;
    o_rsp_valid = '0;
    if (vld_q) o_rsp_valid[id_q] = 1'b1;

    vld_d    = vld_q;
    rnd_d    = rnd_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    // A new transfer overwrites the register even while it drains: no bubble.
    if (accept) begin
      vld_d    = 1'b1;
      rnd_d    = rnd_w;
      id_d     = win;
      rr_ptr_d = (win == IDW'(n_req - 1)) ? '0 : win + IDW'(1);
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  shift_rnd_rne #(
    .width_i     (width_i),
    .width_o     (width_o),
    .width_shift (width_shift)
  ) u_rne (
    .i_num   (op_num),
    .i_shift (op_shift),
    .o_rnd   (rnd_w)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q    <= 1'b0;
      rnd_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      rnd_q    <= rnd_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_rsp_rnd = rnd_q;
  assign o_rsp_id  = id_q;

endmodule

// File: tb/tb_shift_rnd_arb.sv
// Bench for shift_rnd_arb: rounding vector table, directed arbitration corners, random scoreboard.
module tb_shift_rnd_arb;
  import shift_rnd_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req_valid;
  logic [3:0]  o_req_ready;
  logic [35:0] i_req_num;
  logic [31:0] i_req_shift;
  logic [3:0]  o_rsp_valid;
  logic [3:0]  i_rsp_ready;
  logic [7:0]  o_rsp_rnd;
  logic [1:0]  o_rsp_id;

  shift_rnd_arb #(.width_i(9), .width_o(8), .width_shift(8), .n_req(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_num(i_req_num), .i_req_shift(i_req_shift), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready), .o_rsp_rnd(o_rsp_rnd), .o_rsp_id(o_rsp_id)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int id; logic [7:0] rnd; } rsp_t;
  typedef struct { int k; logic [8:0] num; logic [7:0] sh; logic [7:0] exp; } vec_t;

  rsp_t       sb[$];
  vec_t       tbl[18];
  int         n_chk, n_err, n_xfer, n_rsp, mptr;
  logic [3:0] acc;

  // Reference rounding by exact integer division, independent of any bit tricks.
  function automatic logic [7:0] ref_rnd(input logic [8:0] num, input logic [7:0] sh);
    longint v, p, q, r;
    if (sh > 8'd20) return 8'd0;
    v = longint'($signed(num));
    p = longint'(1) << sh;
    r = ((v % p) + p) % p;
    q = (v - r) / p;
    if ((2 * r > p) || ((2 * r == p) && (q[0] == 1'b1))) q = q + 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compares outputs against the scoreboard, then models the edge.
  task automatic monitor();
    logic [3:0] pk, er;
    logic       drain;
    int         w;
    check("rsp_valid", 32'(o_rsp_valid), (sb.size() != 0) ? (32'd1 << sb[0].id) : 32'd0);
    if (sb.size() != 0) begin
      check("rsp_id", 32'(o_rsp_id), sb[0].id);
      check("rsp_rnd", 32'(o_rsp_rnd), 32'(sb[0].rnd));
    end
    if (i_rst) begin
      check("rdy_in_rst", 32'(o_req_ready), 32'd0);
      sb.delete();
      mptr = 0;
      acc  = '0;
      return;
    end
    drain = (sb.size() != 0) && i_rsp_ready[sb[0].id];
    pk = rr_pick(8'(i_req_valid), 3'(mptr), 4);
    er = '0;
    if (pk[3] && ((sb.size() == 0) || drain)) er[pk[1:0]] = 1'b1;
    check("req_ready", 32'(o_req_ready), 32'(er));
    acc = er;
    if (drain) begin
      void'(sb.pop_front());
      n_rsp++;
    end
    if (er != 0) begin
      w = int'(pk[1:0]);
      sb.push_back('{w, ref_rnd(i_req_num[w*9 +: 9], i_req_shift[w*8 +: 8])});
      n_xfer++;
      mptr = (w + 1) % 4;
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req_valid = '0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    int  rem[4];
    int  x0, r0, cyc;
    bit  done;
    n_chk = 0; n_err = 0; n_xfer = 0; n_rsp = 0; mptr = 0; acc = '0;
    tbl[0]  = '{2, 9'h0FF, 8'd0,   8'h7F};
    tbl[1]  = '{0, 9'd5,   8'd1,   8'h02};
    tbl[2]  = '{1, 9'd7,   8'd1,   8'h04};
    tbl[3]  = '{3, 9'h1FB, 8'd1,   8'hFE};
    tbl[4]  = '{0, 9'h1F9, 8'd1,   8'hFC};
    tbl[5]  = '{1, 9'd100, 8'd2,   8'h19};
    tbl[6]  = '{2, 9'd102, 8'd2,   8'h1A};
    tbl[7]  = '{3, 9'd101, 8'd2,   8'h19};
    tbl[8]  = '{0, 9'h100, 8'd0,   8'h80};
    tbl[9]  = '{1, 9'h100, 8'd9,   8'h00};
    tbl[10] = '{2, 9'h100, 8'd8,   8'hFF};
    tbl[11] = '{3, 9'h0FF, 8'd200, 8'h00};
    tbl[12] = '{0, 9'd128, 8'd0,   8'h7F};
    tbl[13] = '{1, 9'h0FF, 8'd1,   8'h7F};
    tbl[14] = '{2, 9'h101, 8'd1,   8'h80};
    tbl[15] = '{3, 9'd3,   8'd2,   8'h01};
    tbl[16] = '{0, 9'd2,   8'd2,   8'h00};
    tbl[17] = '{1, 9'd6,   8'd2,   8'h02};

    // Reset state, with every requester asking.
    i_rst = 1'b1; i_req_valid = '1; i_rsp_ready = '1;
    i_req_num = 36'({$urandom, $urandom}); i_req_shift = $urandom;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rnd", 32'(o_rsp_rnd), 32'd0);
    check("rst_id", 32'(o_rsp_id), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_req_valid = '0;

    // Single-requester rounding vectors.
    foreach (tbl[i]) begin
      i_req_valid = 4'(1) << tbl[i].k;
      i_req_num[tbl[i].k*9 +: 9]   = tbl[i].num;
      i_req_shift[tbl[i].k*8 +: 8] = tbl[i].sh;
      step();
      i_req_valid = '0;
      @(negedge i_clk);
      check("tbl_rnd", 32'(o_rsp_rnd), 32'(tbl[i].exp));
      check("tbl_vld", 32'(o_rsp_valid), 32'd1 << tbl[i].k);
      monitor();
      @(posedge i_clk); #1;
    end

    // All requesters busy, sink always ready: 0,1,2,3,0,... without bubbles.
    do_reset();
    i_req_valid = '1; i_rsp_ready = '1;
    for (int i = 0; i < 8; i++) begin
      i_req_num = 36'({$urandom, $urandom}); i_req_shift = $urandom;
      @(negedge i_clk);
      check("rr_grant", 32'(o_req_ready), 32'd1 << (i % 4));
      if (i > 0) check("no_bubble", 32'(o_rsp_valid), 32'd1 << ((i - 1) % 4));
      monitor();
      @(posedge i_clk); #1;
    end
    i_req_valid = '0;
    step();

    // Result for id 1 stalled five cycles; grant resumes at requester 2.
    do_reset();
    i_req_valid = 4'b0010; i_req_num[9 +: 9] = 9'd77; i_req_shift[8 +: 8] = 8'd1;
    i_rsp_ready = 4'b1101;
    step();
    i_req_valid = '1;
    repeat (5) begin
      @(negedge i_clk);
      check("hold_rdy", 32'(o_req_ready), 32'd0);
      check("hold_vld", 32'(o_rsp_valid), 32'b0010);
      check("hold_rnd", 32'(o_rsp_rnd), 32'd38);
      monitor();
      @(posedge i_clk); #1;
    end
    i_rsp_ready = '1;
    @(negedge i_clk);
    check("resume_grant", 32'(o_req_ready), 32'b0100);
    monitor();
    @(posedge i_clk); #1;
    i_req_valid = '0;
    step(); step();

    // Ready bits of other requesters must not drain the id-0 result.
    do_reset();
    i_req_valid = 4'b0001; i_req_num[0 +: 9] = 9'd40; i_req_shift[0 +: 8] = 8'd3;
    i_rsp_ready = 4'b1110;
    step();
    i_req_valid = '0;
    repeat (3) begin
      @(negedge i_clk);
      check("ign_vld", 32'(o_rsp_valid), 32'b0001);
      check("ign_rnd", 32'(o_rsp_rnd), 32'd5);
      monitor();
      @(posedge i_clk); #1;
    end
    i_rsp_ready = '1;
    step();
    @(negedge i_clk);
    check("ign_drained", 32'(o_rsp_valid), 32'd0);
    monitor();
    @(posedge i_clk); #1;

    // Reset right after a transfer discards the result and restarts the pointer.
    do_reset();
    i_req_valid = 4'b1000;
    step();
    i_rst = 1'b1; i_req_valid = '1;
    @(negedge i_clk);
    check("rdy_during_rst", 32'(o_req_ready), 32'd0);
    monitor();
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_req_valid = 4'b0110;
    @(negedge i_clk);
    check("post_rst_vld", 32'(o_rsp_valid), 32'd0);
    check("post_rst_grant", 32'(o_req_ready), 32'b0010);
    monitor();
    @(posedge i_clk); #1;
    i_req_valid = '0;
    step(); step();

    // Random traffic with random backpressure; each requester issues 25 operations.
    do_reset();
    x0 = n_xfer; r0 = n_rsp; cyc = 0; done = 1'b0;
    foreach (rem[k]) rem[k] = 25;
    while (cyc < 4000) begin
      for (int k = 0; k < 4; k++) begin
        if (!i_req_valid[k] || acc[k]) begin
          if ((rem[k] > 0) && ($urandom_range(3) != 0)) begin
            i_req_valid[k] = 1'b1;
            i_req_num[k*9 +: 9] = 9'($urandom);
            i_req_shift[k*8 +: 8] = ($urandom_range(1) != 0) ? 8'($urandom) : 8'($urandom_range(12));
            rem[k]--;
          end else begin
            i_req_valid[k] = 1'b0;
          end
        end
      end
      i_rsp_ready = 4'($urandom);
      if ((rem[0] + rem[1] + rem[2] + rem[3] == 0) && (i_req_valid == 0) && (sb.size() == 0)) begin
        done = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    check("rand_done", 32'(done), 32'd1);
    check("rand_xfers", n_xfer - x0, 32'd100);
    check("rand_rsps", n_rsp - r0, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/shift_rnd_arb.md
SHIFT_RND_ARB -- requirements
Module: shift_rnd_arb

Interface
REQ-001 Parameter width_i, default 9: requester operand width, signed two's complement.
REQ-002 Parameter width_o, default 8: rounded result width, signed.
REQ-003 Parameter width_shift, default 8: shift operand width, unsigned.
REQ-004 Parameter n_req, default 4: number of requesters, 2..8.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_req_valid  input  n_req  per-requester operation request.
REQ-008 o_req_ready  output  n_req  per-requester accept; one-hot or zero.
REQ-009 i_req_num  input  n_req*width_i  packed operands; requester k occupies bits [k*width_i +: width_i].
REQ-010 i_req_shift  input  n_req*width_shift  packed shift amounts, same packing.
REQ-011 o_rsp_valid  output  n_req  per-requester result valid; one-hot or zero.
REQ-012 i_rsp_ready  input  n_req  per-requester result accept.
REQ-013 o_rsp_rnd  output  width_o  result shared by all requesters.
REQ-014 o_rsp_id  output  $clog2(n_req)  owner of the current result.

Function
REQ-015 The block SHALL share one shift_rnd_rne instance (width_i, width_o, width_shift) among n_req requesters.
REQ-016 A transfer SHALL occur on a request port when i_req_valid[k] and o_req_ready[k] are both high in the same cycle.
REQ-017 o_req_ready SHALL be combinational: one-hot at the grant winner when the output register is empty, or is being drained this cycle (o_rsp_valid & i_rsp_ready nonzero); otherwise zero.
REQ-018 The grant SHALL be round-robin: the winner is the first requester with valid high, searching from pointer rr_ptr upward modulo n_req.
REQ-019 rr_ptr SHALL become (winner+1) mod n_req after each transfer and hold otherwise.
REQ-020 The operands of a transferred request SHALL feed shift_rnd_rne combinationally, and its o_rnd SHALL be registered into the output register with id = winner.
REQ-021 Latency SHALL be exactly 1 cycle: o_rsp_valid[id] rises on the edge that closes the request transfer.
REQ-022 The result SHALL hold stable (o_rsp_rnd, o_rsp_id, o_rsp_valid) while i_rsp_ready[o_rsp_id] is low.
REQ-023 Only i_rsp_ready[o_rsp_id] SHALL matter; ready bits of other requesters are ignored.
REQ-024 A simultaneous drain and new transfer SHALL replace the register contents without a bubble, giving a throughput of 1 per cycle.
REQ-025 o_rsp_rnd SHALL equal bit-exact the shift_rnd_rne output for the granted operands.
REQ-026 Requesters with i_req_valid low SHALL never be granted, and an idle cycle SHALL leave rr_ptr unchanged.

Reset
REQ-027 While i_rst is high at a clock edge: o_rsp_valid=0, o_rsp_rnd=0, o_rsp_id=0, rr_ptr=0.
REQ-028 During reset cycles o_req_ready SHALL be 0 and no transfer SHALL occur.
REQ-029 A result pending when reset is asserted SHALL be discarded, and no partial state SHALL survive.

Structure
REQ-030 A shared package shift_rnd_pkg SHALL hold the default widths and a function that decodes the round-robin winner, which is reused by the bench.
REQ-031 shift_rnd_rne SHALL be the only sub-module, instantiated once and unmodified; the arbiter logic is inline.

Verification
REQ-032 Scenario: after reset, requester 2 alone sends num=9'h0FF, shift=0 -> one cycle later o_rsp_valid=4'b0100, o_rsp_id=2, and o_rsp_rnd equals the DPI reference shift_rnd_rne_ref.
REQ-033 Scenario: all four requesters hold valid with i_rsp_ready all high -> grants are 0,1,2,3,0,... in consecutive cycles, with one result per cycle and no bubbles.
REQ-034 Scenario: result pending for id 1 with i_rsp_ready[1] low for 5 cycles while the others are valid -> o_req_ready=0, the result is stable, and the grant resumes at requester 2 after the drain.
REQ-035 Scenario: i_rsp_ready=4'b1110 while the id-0 result is pending -> the result is not consumed, because ready bits of other requesters are ignored.
REQ-036 Scenario: i_rst asserted the cycle after a transfer -> o_rsp_valid=0 next cycle, and the first post-reset grant goes to the lowest valid index.
REQ-037 Scenario: random stimulus over all num/shift values with random backpressure -> every request yields exactly one response with the correct id, in grant order, with no loss and no duplication.
